// File: rtl/lcd_stream_writer_if.sv
// Byte-stream and lcd16x2 bus bundle for lcd_stream_writer.
// The slave modport is the writer itself; master is the surrounding system.
interface lcd_stream_writer_if;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic [7:0] lcd_data_o;
  logic [1:0] lcd_ops_o;
  logic       lcd_enb_o;
  logic       lcd_rdy_i;
  logic       cursor_row_o;
  logic [4:0] cursor_col_o;

  modport master (
    output char_i, char_valid_i, lcd_rdy_i,
    input  char_ready_o, lcd_data_o, lcd_ops_o, lcd_enb_o, cursor_row_o, cursor_col_o
  );

  modport slave (
    input  char_i, char_valid_i, lcd_rdy_i,
    output char_ready_o, lcd_data_o, lcd_ops_o, lcd_enb_o, cursor_row_o, cursor_col_o
  );
endinterface

// File: rtl/lcd_stream_writer.sv
// Turns a byte stream into lcd16x2 data/instruction writes with cursor tracking.
// Define LCD_STREAM_WRAP_EN to wrap to the next row at the line end instead of discarding.
module lcd_stream_writer #(
  parameter int         NUM_OF_CHARS     = 16,
  parameter logic [7:0] LCD_SETDDRAMADDR = 8'b10000000,
  parameter logic [7:0] LCD_ROW_OFFSET   = 8'b01000000,
  parameter logic [7:0] LCD_CLEAR        = 8'b00000001
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  lcd_stream_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    START,
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    FIXUP
  } state_e;

  localparam logic [1:0] OPS_DATA  = 2'd1;
  localparam logic [1:0] OPS_INSTR = 2'd3;
  localparam logic [4:0] LAST_COL  = 5'(NUM_OF_CHARS - 1);
`ifndef LCD_STREAM_WRAP_EN
  localparam logic [4:0] FULL_COL  = 5'(NUM_OF_CHARS);
`endif

  state_e     state_q, state_d;
  logic       row_q;
  logic [4:0] col_q;
  logic [7:0] pend_data_q, pend_data_d;
  logic [1:0] pend_ops_q, pend_ops_d;
  logic       pend_row_q, pend_row_d;
  logic [4:0] pend_col_q, pend_col_d;
  logic       pend_fix_q, pend_fix_d;
  logic [7:0] data_q;
  logic [1:0] ops_q;
  logic       enb_q;
  logic       load_pend, launch, drop, complete;
  logic       accept;

  assign bus.char_ready_o = rst_ni && (state_q == IDLE);
  assign accept           = bus.char_ready_o && bus.char_valid_i;
  assign bus.lcd_data_o   = data_q;
  assign bus.lcd_ops_o    = ops_q;
  assign bus.lcd_enb_o    = enb_q;
  assign bus.cursor_row_o = row_q;
`ifdef LCD_STREAM_WRAP_EN
  assign bus.cursor_col_o = col_q;
`else
  assign bus.cursor_col_o = (col_q == FULL_COL) ? LAST_COL : col_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // The pending_* set describes the queued operation and the cursor it leaves behind.
  always_comb begin
    state_d     = state_q;
    load_pend   = 1'b0;
    launch      = 1'b0;
    drop        = 1'b0;
    complete    = 1'b0;
    pend_data_d = pend_data_q;
    pend_ops_d  = pend_ops_q;
    pend_row_d  = pend_row_q;
    pend_col_d  = pend_col_q;
    pend_fix_d  = pend_fix_q;

    unique case (state_q)
      START: begin
        load_pend   = 1'b1;
        pend_data_d = LCD_CLEAR;
        pend_ops_d  = OPS_INSTR;
        pend_row_d  = 1'b0;
        pend_col_d  = 5'd0;
        pend_fix_d  = 1'b0;
        state_d     = ISSUE;
      end

      IDLE: begin
        if (accept) begin
          load_pend  = 1'b1;
          pend_fix_d = 1'b0;
          state_d    = ISSUE;
          case (bus.char_i)
            8'h0A: begin
              pend_row_d  = ~row_q;
              pend_col_d  = 5'd0;
              pend_ops_d  = OPS_INSTR;
              pend_data_d = LCD_SETDDRAMADDR | (row_q ? 8'h00 : LCD_ROW_OFFSET);
            end
            8'h0D: begin
              pend_row_d  = row_q;
              pend_col_d  = 5'd0;
              pend_ops_d  = OPS_INSTR;
              pend_data_d = LCD_SETDDRAMADDR | (row_q ? LCD_ROW_OFFSET : 8'h00);
            end
            8'h0C: begin
              pend_row_d  = 1'b0;
              pend_col_d  = 5'd0;
              pend_ops_d  = OPS_INSTR;
              pend_data_d = LCD_CLEAR;
            end
            default: begin
              pend_row_d  = row_q;
              pend_ops_d  = OPS_DATA;
              pend_data_d = bus.char_i;
              if (col_q == LAST_COL) begin
`ifdef LCD_STREAM_WRAP_EN
                pend_row_d = ~row_q;
                pend_col_d = 5'd0;
                pend_fix_d = 1'b1;
`else
                pend_col_d = FULL_COL;
`endif
              end else begin
                pend_col_d = col_q + 5'd1;
              end
`ifndef LCD_STREAM_WRAP_EN
              // Past the line end printable bytes are swallowed without touching the LCD.
              if (col_q == FULL_COL) begin
                load_pend = 1'b0;
                state_d   = IDLE;
              end
`endif
            end
          endcase
        end
      end

      ISSUE: begin
        if (bus.lcd_rdy_i) begin
          launch  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (!bus.lcd_rdy_i) begin
          drop    = 1'b1;
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.lcd_rdy_i) begin
          complete = 1'b1;
          state_d  = pend_fix_q ? FIXUP : IDLE;
        end
      end

      FIXUP: begin
        // Cursor already moved to the new row; re-point DDRAM at its start.
        load_pend   = 1'b1;
        pend_data_d = LCD_SETDDRAMADDR | (row_q ? LCD_ROW_OFFSET : 8'h00);
        pend_ops_d  = OPS_INSTR;
        pend_row_d  = row_q;
        pend_col_d  = col_q;
        pend_fix_d  = 1'b0;
        state_d     = ISSUE;
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q       <= 1'b0;
      col_q       <= 5'd0;
      pend_data_q <= 8'h00;
      pend_ops_q  <= 2'd0;
      pend_row_q  <= 1'b0;
      pend_col_q  <= 5'd0;
      pend_fix_q  <= 1'b0;
      data_q      <= 8'h00;
      ops_q       <= 2'd0;
      enb_q       <= 1'b0;
    end else begin
      if (load_pend) begin
        pend_data_q <= pend_data_d;
        pend_ops_q  <= pend_ops_d;
        pend_row_q  <= pend_row_d;
        pend_col_q  <= pend_col_d;
        pend_fix_q  <= pend_fix_d;
      end
      if (launch) begin
        data_q <= pend_data_q;
        ops_q  <= pend_ops_q;
        enb_q  <= 1'b1;
      end
      if (drop) begin
        enb_q <= 1'b0;
      end
      if (complete) begin
        row_q <= pend_row_q;
        col_q <= pend_col_q;
      end
    end
  end

endmodule

// File: tb/tb_lcd_stream_writer.sv
// Directed bench for lcd_stream_writer: an lcd16x2 responder plus an op scoreboard.
`timescale 1ns/1ps
module tb_lcd_stream_writer;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic hold = 1'b0;
  int   busy = 0;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] sb_q[$];
  logic [9:0] cur_op;
  logic       enb_prev = 1'b0;

  lcd_stream_writer_if bus ();

  lcd_stream_writer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // lcd16x2 responder: goes busy for two cycles after seeing enb, unless held ready.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      bus.lcd_rdy_i = 1'b1;
      busy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) bus.lcd_rdy_i = 1'b1;
    end else if (bus.lcd_enb_o && bus.lcd_rdy_i && !hold) begin
      bus.lcd_rdy_i = 1'b0;
      busy = 2;
    end
  end

  // Scoreboard: every new enb pulse must match the oldest expected op.
  always @(negedge clk_i) begin
    if (bus.lcd_enb_o && !enb_prev) begin
      checkOutput("op_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        cur_op = sb_q.pop_front();
        checkOutput("op", {22'd0, bus.lcd_ops_o, bus.lcd_data_o}, {22'd0, cur_op});
      end
      checkOutput("ready_while_enb", 32'(bus.char_ready_o), 32'd0);
    end else if (bus.lcd_enb_o && enb_prev) begin
      checkOutput("stable_op", {22'd0, bus.lcd_ops_o, bus.lcd_data_o}, {22'd0, cur_op});
      checkOutput("ready_while_enb", 32'(bus.char_ready_o), 32'd0);
    end
    enb_prev = bus.lcd_enb_o;
  end

  task automatic applyStimulus(input logic [7:0] b, input logic expect_op,
                               input logic [1:0] eops, input logic [7:0] edata);
    int n;
    if (expect_op) sb_q.push_back({eops, edata});
    @(negedge clk_i);
    bus.char_i       = b;
    bus.char_valid_i = 1'b1;
    for (n = 0; n < 2000; n++) begin
      if (bus.char_ready_o) break;
      @(negedge clk_i);
    end
    checkOutput("accept_timeout", 32'(n >= 2000), 32'd0);
    @(posedge clk_i);
    #1;
    bus.char_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    if (expect_op) begin
      checkOutput("latency_enb", 32'(bus.lcd_enb_o), 32'd1);
    end else begin
      checkOutput("discard_no_op", 32'(bus.lcd_enb_o), 32'd0);
      checkOutput("discard_idle", 32'(bus.char_ready_o), 32'd1);
    end
  endtask

  task automatic waitIdle(input logic erow, input logic [4:0] ecol);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk_i);
      if (bus.char_ready_o) break;
    end
    checkOutput("idle_timeout", 32'(n >= 2000), 32'd0);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("cursor_row", 32'(bus.cursor_row_o), 32'(erow));
    checkOutput("cursor_col", 32'(bus.cursor_col_o), 32'(ecol));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni           = 1'b0;
    bus.char_i       = 8'h00;
    bus.char_valid_i = 1'b0;
    bus.lcd_rdy_i    = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_enb", 32'(bus.lcd_enb_o), 32'd0);
    checkOutput("rst_ready", 32'(bus.char_ready_o), 32'd0);
    checkOutput("rst_data", 32'(bus.lcd_data_o), 32'd0);
    checkOutput("rst_ops", 32'(bus.lcd_ops_o), 32'd0);
    checkOutput("rst_row", 32'(bus.cursor_row_o), 32'd0);
    checkOutput("rst_col", 32'(bus.cursor_col_o), 32'd0);

    $display("[TB] startup clear");
    sb_q.push_back({2'd3, 8'h01});
    rst_ni = 1'b1;
    waitIdle(1'b0, 5'd0);

    $display("[TB] stream HI newline 0xCB");
    applyStimulus(8'h48, 1'b1, 2'd1, 8'h48);
    applyStimulus(8'h49, 1'b1, 2'd1, 8'h49);
    applyStimulus(8'h0A, 1'b1, 2'd3, 8'hC0);
    applyStimulus(8'hCB, 1'b1, 2'd1, 8'hCB);
    waitIdle(1'b1, 5'd1);

    $display("[TB] carriage return and clear");
    applyStimulus(8'h0D, 1'b1, 2'd3, 8'hC0);
    waitIdle(1'b1, 5'd0);
    applyStimulus(8'h0C, 1'b1, 2'd3, 8'h01);
    waitIdle(1'b0, 5'd0);

    $display("[TB] seventeen A bytes on row 0");
    for (int i = 0; i < 15; i++) applyStimulus(8'h41, 1'b1, 2'd1, 8'h41);
    applyStimulus(8'h41, 1'b1, 2'd1, 8'h41);
`ifdef LCD_STREAM_WRAP_EN
    sb_q.push_back({2'd3, 8'hC0});
    applyStimulus(8'h41, 1'b1, 2'd1, 8'h41);
    waitIdle(1'b1, 5'd1);
    applyStimulus(8'h0A, 1'b1, 2'd3, 8'h80);
    waitIdle(1'b0, 5'd0);
`else
    applyStimulus(8'h41, 1'b0, 2'd0, 8'h00);
    waitIdle(1'b0, 5'd15);
    applyStimulus(8'h0A, 1'b1, 2'd3, 8'hC0);
    waitIdle(1'b1, 5'd0);
`endif

    $display("[TB] hold ready high, then reset in WAIT_BUSY");
    hold = 1'b1;
    applyStimulus(8'h5A, 1'b1, 2'd1, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("hold_enb", 32'(bus.lcd_enb_o), 32'd1);
      checkOutput("hold_data", 32'(bus.lcd_data_o), 32'h5A);
    end
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("midop_rst_enb", 32'(bus.lcd_enb_o), 32'd0);
    checkOutput("midop_rst_ready", 32'(bus.char_ready_o), 32'd0);
    checkOutput("midop_rst_data", 32'(bus.lcd_data_o), 32'd0);
    hold = 1'b0;
    repeat (2) @(negedge clk_i);
    sb_q.push_back({2'd3, 8'h01});
    rst_ni = 1'b1;
    waitIdle(1'b0, 5'd0);

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_stream_writer.md
LCD_STREAM_WRITER -- requirements
Module: lcd_stream_writer

Interface
REQ-001 Parameter NUM_OF_CHARS, default 16, visible columns per row.
REQ-002 Parameter LCD_SETDDRAMADDR, default 8'b10000000, set-DDRAM-address instruction base.
REQ-003 Parameter LCD_ROW_OFFSET, default 8'b01000000, DDRAM offset of row 1.
REQ-004 Parameter LCD_CLEAR, default 8'b00000001, clear-display instruction.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk_i  input  1  clock; every register updates on its rising edge.
REQ-007 rst_ni  input  1  synchronous active-low reset.
REQ-008 char_i  input  8  byte from the upstream stream.
REQ-009 char_valid_i  input  1  char_i valid.
REQ-010 char_ready_o  output  1  block accepts a byte this cycle.
REQ-011 lcd_data_o  output  8  to lcd16x2 data_i.
REQ-012 lcd_ops_o  output  2  to lcd16x2 ops_i; 1 = data write, 3 = instruction write.
REQ-013 lcd_enb_o  output  1  to lcd16x2 enb_i.
REQ-014 lcd_rdy_i  input  1  from lcd16x2 rdy_o.
REQ-015 cursor_row_o  output  1  current row.
REQ-016 cursor_col_o  output  5  current column, 0..NUM_OF_CHARS-1.

Function
REQ-017 The FSM SHALL have states START, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, and FIXUP.
REQ-018 A byte SHALL transfer only on a cycle with char_valid_i=1 and char_ready_o=1; char_ready_o SHALL be 1 only in IDLE.
REQ-019 The lcd16x2 handshake SHALL be: in ISSUE, wait for lcd_rdy_i=1, then drive data/ops and lcd_enb_o=1 and go to WAIT_BUSY. In WAIT_BUSY, on lcd_rdy_i=0 set lcd_enb_o=0 and go to WAIT_DONE. In WAIT_DONE, on lcd_rdy_i=1 the operation completes.
REQ-020 lcd_data_o and lcd_ops_o SHALL hold stable from the assertion of lcd_enb_o until the operation completes.
REQ-021 START SHALL issue instruction LCD_CLEAR, set the cursor to (0,0), then enter IDLE.
REQ-022 A 0x0A byte SHALL move the cursor to column 0 of the other row and issue instruction LCD_SETDDRAMADDR | (row ? LCD_ROW_OFFSET : 0).
REQ-023 A 0x0D byte SHALL move the cursor to column 0 of the same row and issue the matching set-DDRAM instruction.
REQ-024 A 0x0C byte SHALL issue LCD_CLEAR and set the cursor to (0,0).
REQ-025 Any other byte SHALL be written as data (ops 1) and SHALL increment the column.
REQ-026 Column wrap: when a data write completes at column NUM_OF_CHARS-1, the column SHALL become 0 and the row SHALL toggle. FIXUP SHALL then issue the set-DDRAM instruction for the new row before returning to IDLE.
REQ-027 Row wrap: row 1 SHALL advance to row 0 with no scrolling.
REQ-028 A byte presented while the block is not in IDLE SHALL NOT be consumed and SHALL be held by the upstream.
REQ-029 The cursor outputs SHALL update on the cycle the operation completes.
REQ-030 Minimum latency SHALL be 1 cycle from byte acceptance to lcd_enb_o=1, when lcd_rdy_i=1.

Reset
REQ-031 While rst_ni=0: lcd_enb_o=0, char_ready_o=0, lcd_data_o=0, lcd_ops_o=0, cursor=(0,0), FSM in START.
REQ-032 A reset asserted mid-operation SHALL abandon that operation, drop lcd_enb_o on the next edge, and re-run START after release.
REQ-033 char_ready_o SHALL stay 0 after reset until the START clear completes.

Configuration
REQ-034 Macro LCD_STREAM_WRAP_EN. When defined, REQ-026 applies.
REQ-035 When LCD_STREAM_WRAP_EN is undefined:
- once the column reaches NUM_OF_CHARS, further printable bytes SHALL be accepted and discarded with no LCD operation, until 0x0A, 0x0D or 0x0C;
- cursor_col_o SHALL saturate at NUM_OF_CHARS-1.

Verification
REQ-036 Reset, then lcd16x2 model completes ops -> first op is ops=3 data=0x01; char_ready_o rises only after it completes.
REQ-037 Stream "HI\n" + 0xCB -> ops/data sequence 1/0x48, 1/0x49, 3/0xC0, 1/0xCB; cursor ends at (1,1).
REQ-038 With the macro defined, 17 bytes 'A' -> sixteen 1/0x41 writes, 3/0xC0, one 1/0x41; cursor ends at (1,1).
REQ-039 Without the macro, 17 bytes 'A' -> sixteen writes only, and all 17 bytes are accepted; cursor_col_o=15.
REQ-040 Hold lcd_rdy_i=1 for 5 cycles after lcd_enb_o=1 -> lcd_enb_o stays 1, data is stable, and char_ready_o=0.
REQ-041 Drive rst_ni=0 during WAIT_BUSY -> lcd_enb_o=0 on the next edge; after release, clear 3/0x01 is reissued.
